// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result and iterative MUL/DIVU
// Single-cycle ops finish at the accept edge; MUL and DIVU take one bit per cycle.

module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_control,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // MUL: op_a = shifted multiplicand, op_b = shifted multiplier, acc = product.
  // DIV: op_a = dividend shifting into quotient, op_b = divisor, acc = remainder.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;
  logic             last_iter;

  always_comb begin
    single_res = '0;
    case (alu_control)
      3'b000:  single_res = src_a + src_b;
      3'b001:  single_res = src_b - src_a;
      3'b010:  single_res = src_a & src_b;
      3'b011:  single_res = src_a | src_b;
      3'b100:  single_res = src_a ^ src_b;
      3'b101:  single_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      default: single_res = '0;
    endcase

    mul_acc_nxt = acc + (op_b[0] ? op_a : '0);

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    rem_sh      = {acc, op_a[WIDTH-1]};
    rem_sub     = rem_sh - {1'b0, op_b};
    rem_ge      = (rem_sh >= {1'b0, op_b});
    div_rem_nxt = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_quo_nxt = {op_a[WIDTH-2:0], rem_ge};

    last_iter   = (cnt == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      acc         <= '0;
      alu_result  <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a     <= src_a;
            op_b     <= src_b;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (alu_control == 3'b110) begin
              state <= S_MUL;
            end else if (alu_control == 3'b111 && src_b != '0) begin
              state <= S_DIV;
            end else if (alu_control == 3'b111) begin
              state       <= S_DONE;
              alu_result  <= '1;
              zero        <= 1'b0;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
            end else begin
              state       <= S_DONE;
              alu_result  <= single_res;
              zero        <= (single_res == '0);
              div_by_zero <= 1'b0;
              out_valid   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc  <= mul_acc_nxt;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (last_iter) begin
            state       <= S_DONE;
            alu_result  <= mul_acc_nxt;
            zero        <= (mul_acc_nxt == '0);
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
          end
        end
        S_DIV: begin
          acc  <= div_rem_nxt;
          op_a <= div_quo_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (last_iter) begin
            state       <= S_DONE;
            alu_result  <= div_quo_nxt;
            zero        <= (div_quo_nxt == '0);
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
